// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   owner_t     : which requester used the port last (round-robin pointer)
//   arb_state_t : arbiter FSM state (free arbitration or DMA burst lock)
//   BYTEEN_READ : byte-enable value that marks a read access
package dm_port_arbiter_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam logic [3:0] BYTEEN_READ = 4'b0000;

endpackage

// File: rtl/dm_arb_grant.sv
// Combinational grant decision and memory-port mux.
// Ports:
//   locked       : arbiter is in the DMA burst lock state
//   last_is_dma  : the DMA owned the most recent granted beat
//   wait_full    : CPU has waited the maximum number of cycles during a lock
//   cpu_req/addr/wdata/byteen : CPU M-stage access
//   dma_req/addr/wdata/byteen : DMA beat
//   cpu_grant, dma_grant      : one-hot (or zero) grant for this cycle
//   mux_addr/wdata/byteen     : memory port request of the granted side
module dm_arb_grant
    import dm_port_arbiter_pkg::*;
(
    input  logic        locked,
    input  logic        last_is_dma,
    input  logic        wait_full,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    output logic        cpu_grant,
    output logic        dma_grant,
    output logic [31:0] mux_addr,
    output logic [31:0] mux_wdata,
    output logic [3:0]  mux_byteen
);

    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (!locked) begin
            // Contention goes to whoever did not own the last beat.
            if (cpu_req && dma_req) begin
                if (last_is_dma) begin
                    cpu_grant = 1'b1;
                end else begin
                    dma_grant = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_grant = 1'b1;
            end else if (dma_req) begin
                dma_grant = 1'b1;
            end
        end else begin
            // Inside a lock the DMA keeps the port, except for the single
            // preempt beat or a cycle where the DMA has nothing to send.
            if (cpu_req && (wait_full || !dma_req)) begin
                cpu_grant = 1'b1;
            end else if (dma_req) begin
                dma_grant = 1'b1;
            end
        end
    end

    always_comb begin
        mux_addr   = cpu_addr;
        mux_wdata  = '0;
        mux_byteen = BYTEEN_READ;
        if (cpu_grant) begin
            mux_wdata  = cpu_wdata;
            mux_byteen = cpu_byteen;
        end else if (dma_grant) begin
            mux_addr   = dma_addr;
            mux_wdata  = dma_wdata;
            mux_byteen = dma_byteen;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter between the CPU M-stage and a DMA engine.
// Round-robin arbitration, DMA burst lock (bounded by MAX_BURST beats) and a
// CPU preempt beat after CPU_WAIT_LIMIT consecutive stalled cycles.
// The memory reads combinationally and writes on posedge clk, so a granted
// beat completes in its grant cycle.
// Ports:
//   clk, reset (synchronous, active-low)
//   cpu_req/addr/wdata/byteen -> cpu_rdata, cpu_stall
//   dma_req/last/addr/wdata/byteen -> dma_gnt, dma_rdata
//   m_data_addr/wdata/byteen -> memory, m_data_rdata <- memory
//   dma_locked : registered burst-lock indicator
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST      = 8,
    parameter int CPU_WAIT_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_last,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic        dma_locked
);

    // Five bits so that beat_cnt+1 == 16 is representable when MAX_BURST=16.
    localparam logic [4:0] BURST_MAX = 5'(MAX_BURST);
    localparam logic [3:0] WAIT_MAX  = 4'(CPU_WAIT_LIMIT);

    arb_state_t  state, state_nxt;
    owner_t      last_owner, owner_nxt;
    logic [3:0]  beat_cnt, beat_nxt;
    logic [3:0]  wait_cnt, wait_nxt;
    logic [4:0]  beat_inc;

    logic        cpu_grant;
    logic        dma_grant;
    logic        stall_raw;
    logic [3:0]  mux_byteen;

    dm_arb_grant u_grant (
        .locked      (state == ST_LOCK),
        .last_is_dma (last_owner == OWN_DMA),
        .wait_full   (wait_cnt == WAIT_MAX),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_byteen  (cpu_byteen),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_byteen  (dma_byteen),
        .cpu_grant   (cpu_grant),
        .dma_grant   (dma_grant),
        .mux_addr    (m_data_addr),
        .mux_wdata   (m_data_wdata),
        .mux_byteen  (mux_byteen)
    );

    assign stall_raw = cpu_req & ~cpu_grant;

    // While reset is asserted nothing may reach memory or either requester.
    assign cpu_stall     = reset & stall_raw;
    assign dma_gnt       = reset & dma_grant;
    assign m_data_byteen = reset ? mux_byteen : BYTEEN_READ;
    assign dma_locked    = reset & (state == ST_LOCK);

    assign cpu_rdata = m_data_rdata;
    assign dma_rdata = m_data_rdata;

    assign beat_inc = {1'b0, beat_cnt} + 5'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_ARB;
            last_owner <= OWN_DMA;
            beat_cnt   <= 4'd0;
            wait_cnt   <= 4'd0;
        end else begin
            state      <= state_nxt;
            last_owner <= owner_nxt;
            beat_cnt   <= beat_nxt;
            wait_cnt   <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = last_owner;
        beat_nxt  = beat_cnt;
        wait_nxt  = wait_cnt;

        if (cpu_grant) begin
            owner_nxt = OWN_CPU;
        end else if (dma_grant) begin
            owner_nxt = OWN_DMA;
        end

        if (cpu_grant || !cpu_req) begin
            wait_nxt = 4'd0;
        end else if (stall_raw && (wait_cnt != WAIT_MAX)) begin
            wait_nxt = wait_cnt + 4'd1;
        end

        case (state)
            ST_ARB: begin
                // A single-beat transfer (dma_last on the first beat) never locks.
                if (dma_grant && !dma_last) begin
                    state_nxt = ST_LOCK;
                    beat_nxt  = 4'd1;
                end
            end
            ST_LOCK: begin
                // A preempt beat is a CPU grant, so it leaves the lock untouched.
                if (dma_grant) begin
                    if (dma_last || (beat_inc == BURST_MAX)) begin
                        state_nxt = ST_ARB;
                        beat_nxt  = 4'd0;
                    end else begin
                        beat_nxt  = beat_inc[3:0];
                    end
                end
            end
            default: begin
                state_nxt = ST_ARB;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small byte-lane memory model.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_last;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_byteen;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic        dma_locked;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    dm_port_arbiter #(
        .MAX_BURST      (8),
        .CPU_WAIT_LIMIT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_byteen    (cpu_byteen),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .dma_req       (dma_req),
        .dma_last      (dma_last),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_byteen    (dma_byteen),
        .dma_gnt       (dma_gnt),
        .dma_rdata     (dma_rdata),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .dma_locked    (dma_locked)
    );

    // Memory: word i initially holds 0xC0DE_0000 + i; byte-lane writes at posedge.
    assign m_data_rdata = mem[m_data_addr[9:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 32'hC0DE_0000 + 32'(i);
            end
            mem_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (m_data_byteen[b]) begin
                    mem[m_data_addr[9:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        cpu_req    = req;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_byteen = be;
    endtask

    task automatic set_dma(input logic req, input logic last, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        dma_req    = req;
        dma_last   = last;
        dma_addr   = addr;
        dma_wdata  = wdata;
        dma_byteen = be;
    endtask

    task automatic idle();
        set_cpu(1'b0, 32'h0, 32'h0, 4'h0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset held: outputs forced quiet even with both requesting.
        set_cpu(1'b1, 32'h10, 32'h0, 4'h0);
        set_dma(1'b1, 1'b1, 32'h200, 32'h1111_1111, 4'hF);
        @(negedge clk);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rst_byteen", 32'(m_data_byteen), 32'd0);
        check("rst_locked", 32'(dma_locked), 32'd0);

        // First contention after reset goes to the CPU, then alternates.
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rr0_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rr0_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rr0_byteen", 32'(m_data_byteen), 32'd0);
        check("rr0_addr", m_data_addr, 32'h10);
        check("rr0_cpu_rdata", cpu_rdata, 32'hC0DE_0004);
        tick();
        @(negedge clk);
        check("rr1_dma_gnt", 32'(dma_gnt), 32'd1);
        check("rr1_cpu_stall", 32'(cpu_stall), 32'd1);
        check("rr1_addr", m_data_addr, 32'h200);
        check("rr1_wdata", m_data_wdata, 32'h1111_1111);
        check("rr1_byteen", 32'(m_data_byteen), 32'hF);
        tick();
        @(negedge clk);
        check("rr2_dma_gnt", 32'(dma_gnt), 32'd0);
        check("rr2_cpu_stall", 32'(cpu_stall), 32'd0);
        tick();
        @(negedge clk);
        check("rr3_dma_gnt", 32'(dma_gnt), 32'd1);
        tick();
        idle();
        @(negedge clk);
        check("rr_idle_locked", 32'(dma_locked), 32'd0);

        // 4-beat DMA write burst with dma_last on the fourth beat.
        for (int i = 0; i < 4; i++) begin
            tick();
            set_dma(1'b1, (i == 3), 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF);
            @(negedge clk);
            check($sformatf("b4_gnt%0d", i), 32'(dma_gnt), 32'd1);
            check($sformatf("b4_addr%0d", i), m_data_addr, 32'h100 + 32'(4*i));
            check($sformatf("b4_lock%0d", i), 32'(dma_locked), (i > 0) ? 32'd1 : 32'd0);
        end
        tick();
        idle();
        @(negedge clk);
        check("b4_unlock", 32'(dma_locked), 32'd0);
        tick();
        set_cpu(1'b1, 32'h104, 32'h0, 4'h0);
        @(negedge clk);
        check("b4_readback", cpu_rdata, 32'hA000_0001);
        check("b4_rd_stall", 32'(cpu_stall), 32'd0);
        tick();
        set_cpu(1'b1, 32'h200, 32'h0, 4'h0);
        @(negedge clk);
        check("rr_readback", cpu_rdata, 32'h1111_1111);

        // 12-beat burst without dma_last: lock breaks after 8 beats.
        for (int i = 0; i < 8; i++) begin
            tick();
            set_dma(1'b1, 1'b0, 32'h300 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF);
            set_cpu((i == 7), 32'h108, 32'h0, 4'h0);
            @(negedge clk);
            check($sformatf("b12_gnt%0d", i), 32'(dma_gnt), 32'd1);
            check($sformatf("b12_lock%0d", i), 32'(dma_locked), (i >= 1) ? 32'd1 : 32'd0);
        end
        check("b12_cpu_wait", 32'(cpu_stall), 32'd1);
        tick();
        set_dma(1'b1, 1'b0, 32'h320, 32'hB000_0008, 4'hF);
        @(negedge clk);
        check("b12_cpu_stall", 32'(cpu_stall), 32'd0);
        check("b12_dma_held", 32'(dma_gnt), 32'd0);
        check("b12_unlocked", 32'(dma_locked), 32'd0);
        check("b12_cpu_rdata", cpu_rdata, 32'hA000_0002);
        for (int i = 8; i < 12; i++) begin
            tick();
            set_cpu(1'b0, 32'h0, 32'h0, 4'h0);
            set_dma(1'b1, (i == 11), 32'h300 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF);
            @(negedge clk);
            check($sformatf("b12_gnt%0d", i), 32'(dma_gnt), 32'd1);
            check($sformatf("b12_lock%0d", i), 32'(dma_locked), (i > 8) ? 32'd1 : 32'd0);
        end
        tick();
        idle();
        @(negedge clk);
        check("b12_end_unlock", 32'(dma_locked), 32'd0);

        // CPU preempt beat after 4 stalled cycles in a lock.
        tick();
        set_dma(1'b1, 1'b0, 32'h180, 32'hD0D0_D0D0, 4'hF);
        @(negedge clk);
        check("pre_first_gnt", 32'(dma_gnt), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            set_cpu(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
            @(negedge clk);
            check($sformatf("pre_stall%0d", k), 32'(cpu_stall), 32'd1);
            check($sformatf("pre_dgnt%0d", k), 32'(dma_gnt), 32'd1);
        end
        tick();
        @(negedge clk);
        check("pre_cpu_stall", 32'(cpu_stall), 32'd0);
        check("pre_dma_gnt", 32'(dma_gnt), 32'd0);
        check("pre_addr", m_data_addr, 32'h40);
        check("pre_byteen", 32'(m_data_byteen), 32'hF);
        check("pre_locked", 32'(dma_locked), 32'd1);
        check("pre_beat_cnt", 32'(dut.beat_cnt), 32'd5);
        tick();
        set_cpu(1'b0, 32'h0, 32'h0, 4'h0);
        set_dma(1'b1, 1'b1, 32'h180, 32'hD0D0_D0D0, 4'hF);
        @(negedge clk);
        check("pre_resume_gnt", 32'(dma_gnt), 32'd1);
        check("pre_resume_lock", 32'(dma_locked), 32'd1);
        check("pre_resume_beat", 32'(dut.beat_cnt), 32'd5);
        tick();
        idle();
        set_cpu(1'b1, 32'h40, 32'h0, 4'h0);
        @(negedge clk);
        check("pre_end_unlock", 32'(dma_locked), 32'd0);
        check("pre_readback", cpu_rdata, 32'hCAFE_F00D);

        // Reset asserted on the third beat of a burst.
        tick();
        set_cpu(1'b0, 32'h0, 32'h0, 4'h0);
        set_dma(1'b1, 1'b0, 32'h140, 32'hE000_0000, 4'hF);
        @(negedge clk);
        check("mid_gnt0", 32'(dma_gnt), 32'd1);
        tick();
        set_dma(1'b1, 1'b0, 32'h144, 32'hE000_0001, 4'hF);
        @(negedge clk);
        check("mid_lock1", 32'(dma_locked), 32'd1);
        tick();
        set_dma(1'b1, 1'b0, 32'h148, 32'hE000_0002, 4'hF);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_gnt", 32'(dma_gnt), 32'd0);
        check("mid_rst_byteen", 32'(m_data_byteen), 32'd0);
        check("mid_rst_lock", 32'(dma_locked), 32'd0);
        tick();
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("mid_after_lock", 32'(dma_locked), 32'd0);
        check("mid_after_byteen", 32'(m_data_byteen), 32'd0);
        check("mid_after_fsm", 32'(dut.state), 32'd0);
        tick();
        set_cpu(1'b1, 32'h148, 32'h0, 4'h0);
        set_dma(1'b1, 1'b1, 32'h150, 32'hE000_0003, 4'hF);
        @(negedge clk);
        check("mid_cpu_first", 32'(cpu_stall), 32'd0);
        check("mid_dma_wait", 32'(dma_gnt), 32'd0);
        check("mid_not_written", cpu_rdata, 32'hC0DE_0052);
        tick();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (m_data_addr/wdata/byteen/rdata) between the CPU M-stage and a DMA engine.
- The memory reads combinationally and writes on posedge clk, so each granted beat completes in the same cycle as its grant.
- The arbiter gives round-robin access, lets DMA lock the port for bursts, and bounds CPU waiting with a preemption counter.
- Sits between the CPU core's M-stage memory interface and the testbench/bridge data memory.

Parameters:
- MAX_BURST, 8, maximum DMA beats per lock before forced release (2..16).
- CPU_WAIT_LIMIT, 4, consecutive stalled CPU cycles during a DMA lock before the CPU is forced one beat (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- cpu_req  in  1  CPU M-stage memory access valid
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data, already byte-lane aligned
- cpu_byteen  in  4  CPU byte enables; 0 = read
- cpu_rdata  out  32  read data to CPU
- cpu_stall  out  1  CPU must hold M-stage this cycle
- dma_req  in  1  DMA beat valid
- dma_last  in  1  final beat of the current DMA burst
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_byteen  in  4  DMA byte enables; 0 = read
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rdata  out  32  read data to DMA
- m_data_addr  out  32  shared memory address
- m_data_wdata  out  32  shared memory write data
- m_data_byteen  out  4  shared memory byte enables
- m_data_rdata  in  32  shared memory read data
- dma_locked  out  1  DMA burst lock held (registered)

Behaviour:
- Registered state:
  - fsm: ARB or LOCK
  - last_owner: CPU or DMA
  - beat_cnt: 4 bits
  - wait_cnt: 4 bits
- Reset (reset==0 at posedge): fsm=ARB, last_owner=DMA, beat_cnt=0, wait_cnt=0, so the CPU wins the first contention.
- While reset==0, outputs are forced combinationally: cpu_stall=0, dma_gnt=0, m_data_byteen=0, dma_locked=0.
- Grant is combinational from registered state plus current requests. Exactly one requester is granted per cycle, or none.
- ARB grant rules:
  - Only one requester active: that requester is granted.
  - Both active: grant goes to the requester that is not last_owner.
- LOCK grant rules:
  - DMA is granted while dma_req=1.
  - Exception: when wait_cnt==CPU_WAIT_LIMIT and cpu_req=1, the CPU is granted instead (preempt beat).
  - dma_req=0 in LOCK: the CPU may use the port if cpu_req=1; the lock is kept and beat_cnt does not change.
- Muxing:
  - m_data_addr/wdata/byteen come from the granted requester.
  - With no grant: addr=cpu_addr, wdata=0, byteen=0.
  - cpu_rdata and dma_rdata both equal m_data_rdata; each is valid only in its own grant cycle.
- cpu_stall = cpu_req & ~cpu_grant. dma_gnt = dma grant.
- Transitions at posedge:
  - ARB→LOCK: DMA granted with dma_last=0. Set beat_cnt=1.
  - ARB, DMA granted with dma_last=1: stay in ARB.
  - LOCK, DMA granted: beat_cnt+1.
  - LOCK→ARB when dma_last=1, or when beat_cnt+1==MAX_BURST. On exit, last_owner=DMA and beat_cnt=0.
- last_owner updates on every granted beat, including a preempt beat (last_owner=CPU).
- wait_cnt:
  - Increments (saturating at CPU_WAIT_LIMIT) on each cycle with cpu_stall=1.
  - Clears on a CPU grant or when cpu_req=0.
- Preempt beat leaves fsm=LOCK and beat_cnt unchanged; the DMA resumes the next cycle.
- Simultaneous dma_last and preempt: the CPU wins the cycle and the lock stays until the DMA's last beat is actually granted.
- Reset mid-burst: the lock is dropped immediately. The DMA engine must restart its burst.

Decomposition:
- Shared package: owner encoding (OWN_CPU=0, OWN_DMA=1), FSM state encoding, byteen-zero read convention.
- One natural sub-module: dm_arb_grant, the combinational grant/mux logic. The FSM and counters stay in the top module.

Test Plan:
1. Reset hold then release; cpu_req=1, read 0x0000_0010 → m_data_byteen=0, cpu_stall=0, cpu_rdata=m_data_rdata in that cycle. Reset values hold while reset=0.
2. Both request in the first cycle after reset → CPU granted (dma_gnt=0). Both request again next cycle → DMA granted. Grants alternate every cycle.
3. DMA 4-beat write burst to 0x100..0x10C, byteen=F, dma_last on beat 4, CPU idle → dma_gnt=1 for 4 consecutive cycles. dma_locked=1 after beat 1, 0 after beat 4.
4. DMA 12-beat burst, no dma_last, MAX_BURST=8 → lock released after 8 beats. A pending CPU request is granted on the next cycle.
5. DMA locked, CPU stalls continuously with CPU_WAIT_LIMIT=4 → cpu_stall=1 for 4 cycles, then a CPU grant with dma_gnt=0. DMA resumes the next cycle with beat_cnt unchanged.
6. reset driven low during beat 3 of a burst → next cycle fsm=ARB, dma_locked=0, m_data_byteen=0.
